io_port_arbiter: RTL and testbench

//  Shares the single-port memory-mapped I/O block (hex/LED writes, switch reads)

---
 rtl/io_port_arbiter.sv | 153 +++++++++++++++
 tb/tb_io_port_arbiter.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/io_port_arbiter.sv
// io_port_arbiter: two-requester arbiter in front of the single-port memory-mapped I/O block.
// Each accepted access runs IDLE -> ISSUE -> CAPTURE; unmapped or wrong-direction accesses are rejected.
`default_nettype none

module io_port_arbiter #(
  parameter bit          FIXED_PRIO = 1'b0,
  parameter logic [15:0] WR_MASK    = 16'h031F,
  parameter logic [15:0] RD_MASK    = 16'h00E0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req0,
  input  logic        req1,
  input  logic        we0,
  input  logic        we1,
  input  logic [3:0]  addr0,
  input  logic [3:0]  addr1,
  input  logic [31:0] wdata0,
  input  logic [31:0] wdata1,
  output logic        gnt0,
  output logic        gnt1,
  output logic        done0,
  output logic        done1,
  output logic        err0,
  output logic        err1,
  output logic [31:0] rdata0,
  output logic [31:0] rdata1,
  output logic [3:0]  io_addr,
  output logic [31:0] io_data_in,
  output logic        io_we,
  input  logic [31:0] io_data_out,
  output logic        busy
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ISSUE   = 2'd1,
    S_CAPTURE = 2'd2
  } state_t;

  state_t      state_q;
  logic        last_q;      // 1: req1 was granted last, so req0 wins a tie
  logic        owner_q;
  logic        op_we_q;
  logic        gnt0_q, gnt1_q, err0_q, err1_q, done0_q, done1_q;
  logic        io_we_q, busy_q;
  logic [3:0]  io_addr_q;
  logic [31:0] io_data_in_q, rdata0_q, rdata1_q;

  logic        pick0_d, pick1_d, pick_we_d, pick_legal_d;
  logic [3:0]  pick_addr_d;
  logic [31:0] pick_wdata_d;

  // The cycle after any grant is skipped so a still-held request is not granted twice.
  always_comb begin
    pick0_d = 1'b0;
    pick1_d = 1'b0;
    if (state_q == S_IDLE && !gnt0_q && !gnt1_q) begin
      if (req0 && req1) begin
        if (FIXED_PRIO || last_q) pick0_d = 1'b1;
        else                      pick1_d = 1'b1;
      end else if (req0) begin
        pick0_d = 1'b1;
      end else if (req1) begin
        pick1_d = 1'b1;
      end
    end
    pick_we_d    = pick1_d ? we1    : we0;
    pick_addr_d  = pick1_d ? addr1  : addr0;
    pick_wdata_d = pick1_d ? wdata1 : wdata0;
    pick_legal_d = pick_we_d ? WR_MASK[pick_addr_d] : RD_MASK[pick_addr_d];
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      last_q       <= 1'b1;
      owner_q      <= 1'b0;
      op_we_q      <= 1'b0;
      gnt0_q       <= 1'b0;
      gnt1_q       <= 1'b0;
      err0_q       <= 1'b0;
      err1_q       <= 1'b0;
      done0_q      <= 1'b0;
      done1_q      <= 1'b0;
      io_we_q      <= 1'b0;
      busy_q       <= 1'b0;
      io_addr_q    <= 4'd0;
      io_data_in_q <= 32'd0;
      rdata0_q     <= 32'd0;
      rdata1_q     <= 32'd0;
    end else begin
      gnt0_q  <= pick0_d;
      gnt1_q  <= pick1_d;
      err0_q  <= pick0_d & ~pick_legal_d;
      err1_q  <= pick1_d & ~pick_legal_d;
      done0_q <= 1'b0;
      done1_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (pick0_d || pick1_d) begin
            last_q <= pick1_d;
            if (pick_legal_d) begin
              owner_q      <= pick1_d;
              op_we_q      <= pick_we_d;
              io_addr_q    <= pick_addr_d;
              io_data_in_q <= pick_wdata_d;
              io_we_q      <= pick_we_d;
              busy_q       <= 1'b1;
              state_q      <= S_ISSUE;
            end
          end
        end
        S_ISSUE: begin
          io_we_q <= 1'b0;
          state_q <= S_CAPTURE;
        end
        S_CAPTURE: begin
          if (owner_q) begin
            done1_q  <= 1'b1;
            rdata1_q <= op_we_q ? 32'd0 : io_data_out;
          end else begin
            done0_q  <= 1'b1;
            rdata0_q <= op_we_q ? 32'd0 : io_data_out;
          end
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          io_we_q <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign gnt0       = gnt0_q;
  assign gnt1       = gnt1_q;
  assign err0       = err0_q;
  assign err1       = err1_q;
  assign done0      = done0_q;
  assign done1      = done1_q;
  assign rdata0     = rdata0_q;
  assign rdata1     = rdata1_q;
  assign io_addr    = io_addr_q;
  assign io_data_in = io_data_in_q;
  assign io_we      = io_we_q;
  assign busy       = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_io_port_arbiter.sv
// tb_io_port_arbiter: directed and randomized checks of io_port_arbiter against a
// transaction-scheduling reference model.
`default_nettype none

module tb_io_port_arbiter;

  localparam logic [15:0] WR_MASK = 16'h031F;
  localparam logic [15:0] RD_MASK = 16'h00E0;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
  logic [3:0]  addr0 = 4'd0, addr1 = 4'd0;
  logic [31:0] wdata0 = 32'd0, wdata1 = 32'd0, io_data_out = 32'd0;
  logic        gnt0, gnt1, done0, done1, err0, err1, io_we, busy;
  logic [31:0] rdata0, rdata1, io_data_in;
  logic [3:0]  io_addr;
  logic        f_gnt0, f_gnt1, f_done0, f_done1, f_err0, f_err1, f_io_we, f_busy;
  logic [31:0] f_rdata0, f_rdata1, f_io_data_in;
  logic [3:0]  f_io_addr;

  io_port_arbiter #(.FIXED_PRIO(1'b0), .WR_MASK(WR_MASK), .RD_MASK(RD_MASK)) dut (
    .clock(clock), .reset(reset), .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1), .err0(err0), .err1(err1),
    .rdata0(rdata0), .rdata1(rdata1), .io_addr(io_addr), .io_data_in(io_data_in),
    .io_we(io_we), .io_data_out(io_data_out), .busy(busy));

  io_port_arbiter #(.FIXED_PRIO(1'b1), .WR_MASK(WR_MASK), .RD_MASK(RD_MASK)) dut_fp (
    .clock(clock), .reset(reset), .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(f_gnt0), .gnt1(f_gnt1), .done0(f_done0), .done1(f_done1), .err0(f_err0), .err1(f_err1),
    .rdata0(f_rdata0), .rdata1(f_rdata1), .io_addr(f_io_addr), .io_data_in(f_io_data_in),
    .io_we(f_io_we), .io_data_out(io_data_out), .busy(f_busy));

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_errors = 0;
  int k = 0;

  // Reference model: each accepted access is scheduled as a set of future events.
  int          free_at, done_at, busy_until, done_who;
  bit          done_rd, m_last;
  logic [31:0] m_rdata0, m_rdata1, m_data;
  logic [3:0]  m_addr;
  bit          e_gnt0, e_gnt1, e_err0, e_err1, e_done0, e_done1, e_we, e_busy;

  bit hold0 = 0, hold1 = 0, rnd_mode = 0, iod_rand = 1;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, k);
    end
  endtask

  function automatic bit legal(input bit w, input logic [3:0] a);
    return w ? WR_MASK[a] : RD_MASK[a];
  endfunction

  task automatic model_reset();
    free_at = 0; done_at = -1; busy_until = 0; done_who = 0; done_rd = 0; m_last = 1;
    m_rdata0 = 0; m_rdata1 = 0; m_data = 0; m_addr = 0;
    {e_gnt0, e_gnt1, e_err0, e_err1, e_done0, e_done1, e_we, e_busy} = '0;
  endtask

  task automatic model_edge(input bit r0, input bit r1, input bit w0, input bit w1,
                            input logic [3:0] a0, input logic [3:0] a1,
                            input logic [31:0] d0, input logic [31:0] d1, input logic [31:0] iod);
    int win;
    bit lw;
    {e_gnt0, e_gnt1, e_err0, e_err1, e_done0, e_done1, e_we} = '0;
    if (k == done_at) begin
      if (done_who == 1) begin e_done1 = 1; m_rdata1 = done_rd ? iod : 32'd0; end
      else               begin e_done0 = 1; m_rdata0 = done_rd ? iod : 32'd0; end
    end
    if (k >= free_at) begin
      win = -1;
      if (r0 && r1) win = m_last ? 0 : 1;
      else if (r0)  win = 0;
      else if (r1)  win = 1;
      if (win >= 0) begin
        m_last = (win == 1);
        lw = (win == 1) ? w1 : w0;
        if (win == 1) e_gnt1 = 1; else e_gnt0 = 1;
        if (legal(lw, (win == 1) ? a1 : a0)) begin
          m_addr = (win == 1) ? a1 : a0;
          m_data = (win == 1) ? d1 : d0;
          e_we = lw;
          done_at = k + 2; done_who = win; done_rd = !lw;
          busy_until = k + 2; free_at = k + 3;
        end else begin
          if (win == 1) e_err1 = 1; else e_err0 = 1;
          free_at = k + 2;
        end
      end
    end
    e_busy = (k < busy_until);
  endtask

  task automatic check_cycle();
    check_eq("ctrl", {24'd0, gnt0, gnt1, err0, err1, done0, done1, io_we, busy},
             {24'd0, e_gnt0, e_gnt1, e_err0, e_err1, e_done0, e_done1, e_we, e_busy});
    check_eq("rdata0", rdata0, m_rdata0);
    check_eq("rdata1", rdata1, m_rdata1);
    check_eq("io_data_in", io_data_in, m_data);
    if (e_busy) check_eq("io_addr", {28'd0, io_addr}, {28'd0, m_addr});
  endtask

  task automatic new_req(input int p);
    bit w;
    logic [3:0] a;
    w = 1'($urandom_range(1));
    a = 4'($urandom_range(15));
    if ($urandom_range(3) != 0)
      while (!legal(w, a)) begin w = 1'($urandom_range(1)); a = 4'($urandom_range(15)); end
    if (p == 0) begin req0 = 1; we0 = w; addr0 = a; wdata0 = $urandom; end
    else        begin req1 = 1; we1 = w; addr1 = a; wdata1 = $urandom; end
  endtask

  task automatic step();
    bit r0, r1, w0, w1, rs;
    logic [3:0] a0, a1;
    logic [31:0] d0, d1, iod;
    r0 = req0; r1 = req1; w0 = we0; w1 = we1; a0 = addr0; a1 = addr1;
    d0 = wdata0; d1 = wdata1; iod = io_data_out; rs = reset;
    @(posedge clock);
    if (rs) model_reset();
    else    model_edge(r0, r1, w0, w1, a0, a1, d0, d1, iod);
    k++;
    #1;
    check_cycle();
    if (e_gnt0) begin
      if (!hold0) begin if (rnd_mode && $urandom_range(1) == 1) new_req(0); else req0 = 0; end
    end else if (rnd_mode && req0 && $urandom_range(31) == 0) req0 = 0;
    else if (rnd_mode && !req0 && $urandom_range(2) == 0) new_req(0);
    if (e_gnt1) begin
      if (!hold1) begin if (rnd_mode && $urandom_range(1) == 1) new_req(1); else req1 = 0; end
    end else if (rnd_mode && req1 && $urandom_range(31) == 0) req1 = 0;
    else if (rnd_mode && !req1 && $urandom_range(2) == 0) new_req(1);
    if (iod_rand) io_data_out = $urandom;
  endtask

  task automatic do_reset();
    req0 = 0; req1 = 0; hold0 = 0; hold1 = 0;
    reset = 1;
    step();
    step();
    reset = 0;
  endtask

  initial begin
    int last_g, fp0, fp1;
    logic [3:0] ord;
    model_reset();
    do_reset();
    check_eq("reset_ctrl", {24'd0, gnt0, gnt1, err0, err1, done0, done1, io_we, busy}, 32'd0);

    // single write by req0
    req0 = 1; we0 = 1; addr0 = 4'd3; wdata0 = 32'd5;
    step();
    check_eq("t1_gnt0", {31'd0, gnt0}, 32'd1);
    check_eq("t1_io_we", {31'd0, io_we}, 32'd1);
    check_eq("t1_io_addr", {28'd0, io_addr}, 32'd3);
    check_eq("t1_io_data", io_data_in, 32'd5);
    step(); step();
    check_eq("t1_done0", {31'd0, done0}, 32'd1);
    check_eq("t1_rdata0", rdata0, 32'd0);

    // single read by req1 with fixed I/O data
    iod_rand = 0; io_data_out = 32'h1A;
    req1 = 1; we1 = 0; addr1 = 4'd5;
    step(); step(); step();
    check_eq("t2_done1", {31'd0, done1}, 32'd1);
    check_eq("t2_rdata1", rdata1, 32'h1A);
    iod_rand = 1;
    step();

    // contention: both held, round-robin vs fixed priority
    do_reset();
    req0 = 1; we0 = 0; addr0 = 4'd6; req1 = 1; we1 = 0; addr1 = 4'd7;
    hold0 = 1; hold1 = 1; ord = 4'd0; fp0 = 0; fp1 = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (gnt0 || gnt1) ord = {ord[2:0], gnt1};
      fp0 += int'(f_gnt0); fp1 += int'(f_gnt1);
    end
    check_eq("t3_rr_order", {28'd0, ord}, 32'h5);
    check_eq("t3_fp_gnt0", fp0, 32'd4);
    check_eq("t3_fp_gnt1", fp1, 32'd0);
    hold0 = 0; hold1 = 0; req0 = 0; req1 = 0;
    repeat (4) step();

    // illegal accesses: unmapped write, then read of a write-only address
    req0 = 1; we0 = 1; addr0 = 4'd12;
    step();
    check_eq("t4_err0_a", {30'd0, gnt0, err0}, 32'd3);
    step(); step();
    req0 = 1; we0 = 0; addr0 = 4'd3;
    step();
    check_eq("t4_err0_b", {30'd0, gnt0, err0}, 32'd3);
    check_eq("t4_busy", {30'd0, busy, io_we}, 32'd0);
    repeat (3) step();

    // reset mid-write aborts the access at once
    req0 = 1; we0 = 1; addr0 = 4'd1; wdata0 = 32'hCAFE;
    step();
    #2 reset = 1;
    #1;
    model_reset();
    check_eq("t5_abort", {29'd0, io_we, busy, done0}, 32'd0);
    req0 = 1; we0 = 0; addr0 = 4'd5; req1 = 1; we1 = 0; addr1 = 4'd6;
    step();
    reset = 0;
    step();
    check_eq("t5_first", {30'd0, gnt0, gnt1}, 32'd2);
    repeat (4) step();

    // back-to-back reads by a held req0
    req1 = 0; req0 = 1; we0 = 0; addr0 = 4'd7; hold0 = 1;
    repeat (3) step();
    last_g = -1;
    for (int i = 0; i < 12; i++) begin
      step();
      if (gnt0) begin
        if (last_g >= 0) check_eq("t6_spacing", k - last_g, 32'd3);
        last_g = k;
      end
    end
    hold0 = 0; req0 = 0;
    repeat (4) step();

    // randomized traffic
    rnd_mode = 1;
    for (int i = 0; i < 2000; i++) step();
    rnd_mode = 0; req0 = 0; req1 = 0;
    repeat (6) step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule

`default_nettype wire
